// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: shared latencies, register width and in-flight entry type for the multiply issue controller
// Contents: MUL_LAT_DEF (multiply latency), ALU_LAT_DEF (ALU latency), REG_W (register index width),
//           inflight_entry_t {valid, regdest}
package mult_ctrl_pkg;
    localparam int MUL_LAT_DEF = 3;
    localparam int ALU_LAT_DEF = 1;
    localparam int REG_W = 5;
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] regdest;
    } inflight_entry_t;
endpackage

// File: rtl/mult_inflight_table.sv
// mult_inflight_table: shift table of in-flight multiply destinations with three-way register match
// Ports: clock, reset (sync, active-high); push_valid/push_regdest load the youngest slot;
//        rs/rt/rd are compared against every valid slot -> rs_match/rt_match/rd_match;
//        head_valid is the slot aligned with multiplier stage 3
module mult_inflight_table
    import mult_ctrl_pkg::*;
#(
    parameter int DEPTH = MUL_LAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [REG_W-1:0] push_regdest,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    output logic             rs_match,
    output logic             rt_match,
    output logic             rd_match,
    output logic             head_valid
);
    inflight_entry_t [DEPTH-1:0] pipe;

    // Slot DEPTH-1 is loaded on issue and walks down to slot 0 in step with the multiplier stages.
    always_ff @(posedge clock) begin
        if (reset)
            pipe <= '0;
        else
            pipe <= {push_valid, push_regdest, pipe[DEPTH-1:1]};
    end

    always_comb begin
        rs_match = 1'b0;
        rt_match = 1'b0;
        rd_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            rs_match = rs_match | (pipe[k].valid & (pipe[k].regdest == rs));
            rt_match = rt_match | (pipe[k].valid & (pipe[k].regdest == rt));
            rd_match = rd_match | (pipe[k].valid & (pipe[k].regdest == rd));
        end
    end

    assign head_valid = pipe[0].valid;
endmodule

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: decode-stage issue/hazard control for the 3-stage multiplier with shared writeback port
// Ports: clock, reset (sync, active-high)
//        id_valid/id_is_mul/id_regwrite, id_rs/id_rt with id_rs_used/id_rt_used, id_regdest: decode instruction
//        m3_mul_writereg: stage-3 writeback strobe; ovf_clear: clears mul_ovf_sticky
//        id_stall, m1_oper, m1_regdest: combinational stall and issue controls
//        mul_ovf_pulse, mul_ovf_sticky, sync_err: registered status flags
//        perf_haz_cnt, perf_wb_cnt: saturating stall counters, live only with MULT_ISSUE_PERF_EN defined
module mult_issue_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int ALU_LAT = ALU_LAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_is_mul,
    input  logic             id_regwrite,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_regdest,
    input  logic             m3_mul_writereg,
    input  logic             ovf_clear,
    output logic             id_stall,
    output logic             m1_oper,
    output logic [REG_W-1:0] m1_regdest,
    output logic             mul_ovf_pulse,
    output logic             mul_ovf_sticky,
    output logic             sync_err,
    output logic [31:0]      perf_haz_cnt,
    output logic [31:0]      perf_wb_cnt
);
    logic [MUL_LAT-1:0] rsv;
    logic [MUL_LAT-1:0] rsv_view;
    logic rs_m, rt_m, rd_m, head_valid, haz, wbc, drop;

    mult_inflight_table #(.DEPTH(MUL_LAT)) u_table (
        .clock       (clock),
        .reset       (reset),
        .push_valid  (m1_oper),
        .push_regdest(m1_regdest),
        .rs          (id_rs),
        .rt          (id_rt),
        .rd          (id_regdest),
        .rs_match    (rs_m),
        .rt_match    (rt_m),
        .rd_match    (rd_m),
        .head_valid  (head_valid)
    );

    // rsv holds the reservations as seen at the end of the previous cycle; shifting by one
    // re-bases it to this cycle, so rsv_view[k] means the port is taken k+1 cycles from now.
    assign rsv_view = rsv >> 1;

    // Register 0 never hazards; outputs are forced quiet while reset is asserted.
    always_comb begin
        haz = ~reset & id_valid &
              ((id_rs_used & (id_rs != '0) & rs_m) |
               (id_rt_used & (id_rt != '0) & rt_m) |
               (id_regwrite & (id_regdest != '0) & rd_m));
        wbc = ~reset & id_valid & ~id_is_mul & id_regwrite & rsv_view[ALU_LAT-1];
        id_stall = haz | wbc;
        m1_oper = ~reset & id_valid & id_is_mul & ~id_stall;
        m1_regdest = m1_oper ? id_regdest : '0;
        drop = head_valid & ~m3_mul_writereg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsv <= '0;
            mul_ovf_pulse <= 1'b0;
            mul_ovf_sticky <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            rsv <= rsv_view | {m1_oper, {(MUL_LAT-1){1'b0}}};
            mul_ovf_pulse <= drop;
            mul_ovf_sticky <= drop | (mul_ovf_sticky & ~ovf_clear);
            sync_err <= sync_err | (m3_mul_writereg & ~head_valid);
        end
    end

`ifdef MULT_ISSUE_PERF_EN
    // A cycle stalled by both causes is charged to the hazard counter only.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_haz_cnt <= '0;
            perf_wb_cnt <= '0;
        end else begin
            if (haz && perf_haz_cnt != '1)
                perf_haz_cnt <= perf_haz_cnt + 32'd1;
            if (wbc && !haz && perf_wb_cnt != '1)
                perf_wb_cnt <= perf_wb_cnt + 32'd1;
        end
    end
`else
    assign perf_haz_cnt = '0;
    assign perf_wb_cnt = '0;
`endif
endmodule
